// File: rtl/acc_core_p_if.sv
// Instruction-fetch bus of acc_core_p: fetch address, request, and the returned instruction word with its valid.
// The core drives the master side and the instruction source drives the slave side.
interface acc_core_p_if #(
  parameter int OPD_W = 4,
  parameter int PC_W  = 8
);
  logic [OPD_W+3:0] instr_in;
  logic             instr_valid;
  logic             instr_req;
  logic [PC_W-1:0]  pc_out;

  modport master (input instr_in, instr_valid, output instr_req, pc_out);
  modport slave  (output instr_in, instr_valid, input instr_req, pc_out);
endinterface

// File: rtl/acc_core_p.sv
// Parametrised accumulator core: register file, PC, IR, and a FETCH/EXEC/HALT controller with a stallable fetch.
// Optional macro ACC_CORE_P_RETIRE_CNT_EN adds a saturating 16-bit retire_cnt output.
module acc_core_p #(
  parameter int DATA_W = 8,
  parameter int OPD_W  = 4,
  parameter int PC_W   = 8
) (
  input  logic                   clk,
  input  logic                   CLB,
  acc_core_p_if.master           fbus,
  output logic [DATA_W-1:0]      acc_out,
  output logic                   zflag,
  output logic                   cflag,
  output logic                   halted,
  output logic                   retire,
  output logic [PC_W+DATA_W-1:0] proc_out
`ifdef ACC_CORE_P_RETIRE_CNT_EN
  ,
  output logic [15:0]            retire_cnt
`endif
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_EXEC  = 2'd1;
  localparam logic [1:0] S_HALT  = 2'd2;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_LDR  = 4'h2;
  localparam logic [3:0] OP_STR  = 4'h3;
  localparam logic [3:0] OP_ADD  = 4'h4;
  localparam logic [3:0] OP_SUB  = 4'h5;
  localparam logic [3:0] OP_AND  = 4'h6;
  localparam logic [3:0] OP_OR   = 4'h7;
  localparam logic [3:0] OP_XOR  = 4'h8;
  localparam logic [3:0] OP_SHL  = 4'h9;
  localparam logic [3:0] OP_SHR  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_JC   = 4'hD;
  localparam logic [3:0] OP_JMPA = 4'hE;
  localparam logic [3:0] OP_HLT  = 4'hF;

  localparam int NREGS = 2 ** OPD_W;

  logic [1:0]        state;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] acc;
  logic [OPD_W+3:0]  ir;
  logic              zf, cf;
  logic [DATA_W-1:0] regs [NREGS];

  logic [3:0]        opcode;
  logic [OPD_W-1:0]  operand;
  logic [DATA_W-1:0] opd_d, r_val, acc_nx;
  logic [DATA_W:0]   sum, diff;
  logic              acc_wr, c_wr, c_nx, reg_wr, br_taken;
  logic [PC_W-1:0]   br_tgt;

  assign opcode  = ir[3:0];
  assign operand = ir[OPD_W+3:4];
  assign opd_d   = DATA_W'(operand);
  assign r_val   = regs[operand];
  assign sum     = {1'b0, acc} + {1'b0, r_val};
  // The extra top bit of the widened difference is the borrow, set exactly when acc < R.
  assign diff    = {1'b0, acc} - {1'b0, r_val};

  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    acc_nx   = acc;
    acc_wr   = 1'b0;
    c_nx     = cf;
    c_wr     = 1'b0;
    reg_wr   = 1'b0;
    br_taken = 1'b0;
    br_tgt   = PC_W'(operand);
    case (opcode)
      OP_LDI:  begin acc_nx = opd_d;         acc_wr = 1'b1; end
      OP_LDR:  begin acc_nx = r_val;         acc_wr = 1'b1; end
      OP_STR:  reg_wr = 1'b1;
      OP_ADD:  begin acc_nx = sum[DATA_W-1:0];  c_nx = sum[DATA_W];  acc_wr = 1'b1; c_wr = 1'b1; end
      OP_SUB:  begin acc_nx = diff[DATA_W-1:0]; c_nx = diff[DATA_W]; acc_wr = 1'b1; c_wr = 1'b1; end
      OP_AND:  begin acc_nx = acc & r_val;   acc_wr = 1'b1; end
      OP_OR:   begin acc_nx = acc | r_val;   acc_wr = 1'b1; end
      OP_XOR:  begin acc_nx = acc ^ r_val;   acc_wr = 1'b1; end
      OP_SHL:  begin acc_nx = {acc[DATA_W-2:0], 1'b0}; c_nx = acc[DATA_W-1]; acc_wr = 1'b1; c_wr = 1'b1; end
      OP_SHR:  begin acc_nx = {1'b0, acc[DATA_W-1:1]}; c_nx = acc[0];        acc_wr = 1'b1; c_wr = 1'b1; end
      OP_JMP:  br_taken = 1'b1;
      OP_JZ:   br_taken = zf;
      OP_JC:   br_taken = cf;
      OP_JMPA: begin br_taken = 1'b1; br_tgt = PC_W'(acc); end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      state <= S_FETCH;
      pc    <= '0;
      acc   <= '0;
      ir    <= '0;
      zf    <= 1'b0;
      cf    <= 1'b0;
    end else begin
      case (state)
        S_FETCH: if (fbus.instr_valid) begin
          ir    <= fbus.instr_in;
          pc    <= pc + PC_W'(1);
          state <= S_EXEC;
        end
        S_EXEC: begin
          if (acc_wr) begin
            acc <= acc_nx;
            zf  <= (acc_nx == '0);
          end
          if (c_wr)     cf <= c_nx;
          if (br_taken) pc <= br_tgt;
          state <= (opcode == OP_HLT) ? S_HALT : S_FETCH;
        end
        S_HALT:  ;
        default: state <= S_FETCH;
      endcase
    end
  end

  // NOTE: the register file is architecturally cleared by reset, so it is built from resettable flops, not a RAM.
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state == S_EXEC && reg_wr) begin
      regs[operand] <= acc;
    end
  end

  assign fbus.instr_req = (state == S_FETCH);
  assign fbus.pc_out    = pc;
  assign acc_out        = acc;
  assign zflag          = zf;
  assign cflag          = cf;
  assign halted         = (state == S_HALT);
  assign retire         = (state == S_EXEC);
  assign proc_out       = {pc, acc};

`ifdef ACC_CORE_P_RETIRE_CNT_EN
  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB)                                retire_cnt <= '0;
    else if (retire && retire_cnt != 16'hFFFF) retire_cnt <= retire_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_acc_core_p.sv
// Directed self-checking bench for acc_core_p: reset, ALU/flags, branches, fetch stall, halt and PC wrap.
// Inputs change and outputs are sampled on the falling edge; the core acts on the rising edge.
module tb_acc_core_p;
  logic clk = 1'b0;
  logic CLB = 1'b0;
  logic [7:0]  acc_out;
  logic        zflag, cflag, halted, retire;
  logic [15:0] proc_out;
`ifdef ACC_CORE_P_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  int errors = 0;
  int checks = 0;
  int n_ret  = 0;
  int base   = 0;

  acc_core_p_if #(.OPD_W(4), .PC_W(8)) bus ();

  acc_core_p #(.DATA_W(8), .OPD_W(4), .PC_W(8)) dut (
    .clk(clk), .CLB(CLB), .fbus(bus.master),
    .acc_out(acc_out), .zflag(zflag), .cflag(cflag), .halted(halted),
    .retire(retire), .proc_out(proc_out)
`ifdef ACC_CORE_P_RETIRE_CNT_EN
    , .retire_cnt(retire_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(negedge clk) if (retire === 1'b1) n_ret++;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    CLB = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_in = 8'h00;
    @(negedge clk); @(negedge clk);
    CLB = 1'b1;
    @(negedge clk);
    #1 base = n_ret;
  endtask

  // Present one instruction in FETCH, confirm its EXEC cycle retires, and return to the next falling edge after EXEC.
  task automatic issue(input logic [7:0] ins);
    checks++;
    if (bus.instr_req !== 1'b1) begin
      errors++;
      $display("FAIL issue_req ins=%h: instr_req=%b want 1", ins, bus.instr_req);
    end
    bus.instr_in = ins;
    bus.instr_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.instr_valid = 1'b0;
    checks++;
    if (retire !== 1'b1) begin
      errors++;
      $display("FAIL issue_retire ins=%h: retire=%b want 1", ins, retire);
    end
    @(posedge clk); @(negedge clk);
  endtask

  task automatic check_state(input string name, input logic [7:0] pc_e, input logic [7:0] acc_e,
                             input logic z_e, input logic c_e);
    checks++;
    if (bus.pc_out !== pc_e || acc_out !== acc_e || zflag !== z_e || cflag !== c_e) begin
      errors++;
      $display("FAIL %s: pc=%h acc=%h z=%b c=%b want pc=%h acc=%h z=%b c=%b",
               name, bus.pc_out, acc_out, zflag, cflag, pc_e, acc_e, z_e, c_e);
    end
  endtask

  task automatic test_reset;
    CLB = 1'b0;
    bus.instr_valid = 1'b0;
    bus.instr_in = 8'h00;
    @(negedge clk);
    checks++;
    if (bus.pc_out !== 8'h00 || acc_out !== 8'h00 || zflag !== 1'b0 || cflag !== 1'b0 ||
        halted !== 1'b0 || retire !== 1'b0) begin
      errors++;
      $display("FAIL reset_initial: pc=%h acc=%h z=%b c=%b halted=%b retire=%b want all 0",
               bus.pc_out, acc_out, zflag, cflag, halted, retire);
    end
    @(negedge clk);
    CLB = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.instr_req !== 1'b1 || proc_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release: instr_req=%b proc_out=%h want 1 0000", bus.instr_req, proc_out);
    end
    // Load R2=9 and acc=9, then abort a LDI 6 in its EXEC cycle with reset.
    issue(8'h91);
    issue(8'h23);
    check_state("reset_preload", 8'h02, 8'h09, 1'b0, 1'b0);
    bus.instr_in = 8'h61;
    bus.instr_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    bus.instr_valid = 1'b0;
    CLB = 1'b0;
    #1;
    checks++;
    if (bus.pc_out !== 8'h00 || acc_out !== 8'h00 || zflag !== 1'b0 || cflag !== 1'b0 ||
        halted !== 1'b0 || retire !== 1'b0) begin
      errors++;
      $display("FAIL reset_midexec: pc=%h acc=%h z=%b c=%b halted=%b retire=%b want all 0",
               bus.pc_out, acc_out, zflag, cflag, halted, retire);
    end
    @(negedge clk);
    CLB = 1'b1;
    @(negedge clk);
    checks++;
    if (bus.instr_req !== 1'b1 || proc_out !== 16'h0000) begin
      errors++;
      $display("FAIL reset_midexec_release: instr_req=%b proc_out=%h want 1 0000", bus.instr_req, proc_out);
    end
    issue(8'h22);
    check_state("reset_regfile_cleared", 8'h01, 8'h00, 1'b1, 1'b0);
  endtask

  task automatic test_arith;
    int r0;
    do_reset();
    r0 = n_ret;
    issue(8'h51);
    issue(8'h33);
    issue(8'h71);
    issue(8'h34);
    check_state("arith_add", 8'h04, 8'h0C, 1'b0, 1'b0);
    #1;
    checks++;
    if (n_ret - r0 !== 4) begin
      errors++;
      $display("FAIL arith_retire_count: got %0d want 4", n_ret - r0);
    end
  endtask

  task automatic test_carry;
    do_reset();
    issue(8'hF1);
    for (int i = 0; i < 4; i++) issue(8'h09);
    check_state("carry_shl4", 8'h05, 8'hF0, 1'b0, 1'b0);
    issue(8'h13);
    issue(8'h14);
    check_state("carry_add", 8'h07, 8'hE0, 1'b0, 1'b1);
    issue(8'h01);
    check_state("carry_ldi0_holds_c", 8'h08, 8'h00, 1'b1, 1'b1);
    issue(8'h15);
    check_state("carry_sub_borrow", 8'h09, 8'h10, 1'b0, 1'b1);
    issue(8'hC1);
    issue(8'h17);
    check_state("logic_or", 8'h0B, 8'hFC, 1'b0, 1'b1);
    issue(8'h18);
    check_state("logic_xor", 8'h0C, 8'h0C, 1'b0, 1'b1);
    issue(8'h16);
    check_state("logic_and_zero", 8'h0D, 8'h00, 1'b1, 1'b1);
    issue(8'h21);
    issue(8'h0A);
    check_state("shr_no_carry", 8'h0F, 8'h01, 1'b0, 1'b0);
    issue(8'h0A);
    check_state("shr_carry_zero", 8'h10, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_branch;
    do_reset();
    issue(8'h01);
    issue(8'h9C);
    check_state("jz_taken", 8'h09, 8'h00, 1'b1, 1'b0);
    issue(8'h5D);
    check_state("jc_not_taken", 8'h0A, 8'h00, 1'b1, 1'b0);
    issue(8'h31);
    issue(8'h2C);
    check_state("jz_not_taken", 8'h0C, 8'h03, 1'b0, 1'b0);
    issue(8'h0E);
    check_state("jmpa", 8'h03, 8'h03, 1'b0, 1'b0);
    issue(8'h11);
    issue(8'h0A);
    issue(8'h7D);
    check_state("jc_taken", 8'h07, 8'h00, 1'b1, 1'b1);
    issue(8'hEB);
    check_state("jmp", 8'h0E, 8'h00, 1'b1, 1'b1);
  endtask

  task automatic test_stall;
    int r0;
    do_reset();
    issue(8'h71);
    #1 r0 = n_ret;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (bus.instr_req !== 1'b1 || bus.pc_out !== 8'h01 || acc_out !== 8'h07 || retire !== 1'b0) begin
        errors++;
        $display("FAIL stall_cycle%0d: req=%b pc=%h acc=%h retire=%b want 1 01 07 0",
                 i, bus.instr_req, bus.pc_out, acc_out, retire);
      end
    end
    #1;
    checks++;
    if (n_ret !== r0) begin
      errors++;
      $display("FAIL stall_no_retire: retires=%0d want 0", n_ret - r0);
    end
    issue(8'h21);
    check_state("stall_resume", 8'h02, 8'h02, 1'b0, 1'b0);
  endtask

  task automatic test_halt_wrap;
    do_reset();
    issue(8'hF1);
    for (int i = 0; i < 4; i++) issue(8'h09);
    issue(8'h13);
    issue(8'hF1);
    issue(8'h17);
    issue(8'h0E);
    check_state("jump_to_ff", 8'hFF, 8'hFF, 1'b0, 1'b0);
    issue(8'h00);
    check_state("pc_wrap", 8'h00, 8'hFF, 1'b0, 1'b0);
    issue(8'h0F);
    bus.instr_in = 8'h51;
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (halted !== 1'b1 || bus.instr_req !== 1'b0 || retire !== 1'b0 ||
          bus.pc_out !== 8'h01 || acc_out !== 8'hFF) begin
        errors++;
        $display("FAIL halt_hold%0d: halted=%b req=%b retire=%b pc=%h acc=%h want 1 0 0 01 ff",
                 i, halted, bus.instr_req, retire, bus.pc_out, acc_out);
      end
    end
    bus.instr_valid = 1'b0;
    #1;
    checks++;
    if (n_ret - base !== 11) begin
      errors++;
      $display("FAIL halt_retire_count: got %0d want 11", n_ret - base);
    end
`ifdef ACC_CORE_P_RETIRE_CNT_EN
    checks++;
    if (retire_cnt !== 16'd11) begin
      errors++;
      $display("FAIL retire_cnt: got %0d want 11", retire_cnt);
    end
`endif
    do_reset();
    checks++;
    if (halted !== 1'b0 || bus.instr_req !== 1'b1 || proc_out !== 16'h0000) begin
      errors++;
      $display("FAIL halt_reset: halted=%b req=%b proc_out=%h want 0 1 0000",
               halted, bus.instr_req, proc_out);
    end
`ifdef ACC_CORE_P_RETIRE_CNT_EN
    checks++;
    if (retire_cnt !== 16'd0) begin
      errors++;
      $display("FAIL retire_cnt_reset: got %0d want 0", retire_cnt);
    end
`endif
  endtask

  initial begin
    bus.instr_valid = 1'b0;
    bus.instr_in = 8'h00;
    test_reset();
    test_arith();
    test_carry();
    test_branch();
    test_stall();
    test_halt_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
